// File: rtl/codec_intf.sv
// CS4272 left-justified serial master: SCLK/LRCLK generation, ADC deserialiser, DAC serialiser.
// Build option: define CODEC_LOOPBACK_EN to feed received samples back to the DAC.
module codec_intf #(
  parameter int unsigned DW = 16
) (
  input  logic          MCLK,
  input  logic          RSTn,
  output logic          SCLK,
  output logic          LRCLK,
  input  logic          SDout,
  output logic          SDin,
  input  logic [DW-1:0] lft_out,
  input  logic [DW-1:0] rht_out,
  output logic [DW-1:0] lft_in,
  output logic [DW-1:0] rht_in,
  output logic          valid,
  output logic          tx_ack
);

  localparam logic [7:0] RX_LAST  = 8'(DW * 4 - 2);
  localparam logic [7:0] TX_LOAD  = 8'((64 - DW) * 4 - 1);
  localparam logic [6:0] RX_SLOTS = 7'(DW);
  localparam logic [5:0] TX_FIRST = 6'(64 - DW);

  logic [8:0]    cnt, cnt_nxt;
  logic [DW-1:0] rx_sh, rx_nxt, lft_stage;
  logic [DW-1:0] tx_sh, tx_d, src_l, src_r;
  logic          primed;
  logic          rx_shift, rx_last, tx_load, sdin_d;

  // Both serial clocks are plain counter bits, hence flop-driven and glitch-free.
  assign SCLK  = cnt[1];
  assign LRCLK = cnt[8];

`ifdef CODEC_LOOPBACK_EN
  assign src_l = lft_in;
  assign src_r = rht_in;
`else
  assign src_l = lft_out;
  assign src_r = rht_out;
`endif

  always_comb begin
    cnt_nxt  = cnt + 9'd1;
    rx_shift = (cnt[1:0] == 2'b10) && ({1'b0, cnt[7:2]} < RX_SLOTS);
    rx_last  = (cnt[7:0] == RX_LAST);
    tx_load  = (cnt[7:0] == TX_LOAD);
    rx_nxt   = DW'({rx_sh, SDout});
    if (tx_load)                tx_d = cnt[8] ? src_l : src_r;
    else if (cnt[1:0] == 2'b11) tx_d = DW'({tx_sh, 1'b0});
    else                        tx_d = tx_sh;
    // SDin is registered, so gate it with the slot index the counter is about to enter.
    sdin_d = (cnt_nxt[7:2] >= TX_FIRST) ? tx_d[DW-1] : 1'b0;
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt       <= '0;
      rx_sh     <= '0;
      lft_stage <= '0;
      primed    <= 1'b0;
      lft_in    <= '0;
      rht_in    <= '0;
      valid     <= 1'b0;
      tx_sh     <= '0;
      SDin      <= 1'b0;
      tx_ack    <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      valid  <= 1'b0;
      tx_ack <= 1'b0;
      tx_sh  <= tx_d;
      SDin   <= sdin_d;
      if (rx_shift) rx_sh <= rx_nxt;
      // The final slot's bit is taken straight from rx_nxt, not the not-yet-updated rx_sh.
      if (rx_last) begin
        if (cnt[8]) begin
          lft_stage <= rx_nxt;
          primed    <= 1'b1;
        end else if (primed) begin
          lft_in <= lft_stage;
          rht_in <= rx_nxt;
          valid  <= 1'b1;
        end
      end
      if (tx_load && !cnt[8]) tx_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// Scoreboard bench for codec_intf: a behavioural CS4272 model drives SDout and captures SDin,
// expected samples are queued when issued and popped when the DUT presents them.
module tb_codec_intf;
  localparam int unsigned DW    = 16;
  localparam int unsigned LD_R  = (64 - DW) * 4 - 1;
  localparam int unsigned LD_L  = 256 + LD_R;
  localparam int unsigned ACK_T = (64 - DW) * 4;
  localparam int unsigned VLD_T = DW * 4 - 1;

  logic          MCLK = 1'b0;
  logic          RSTn = 1'b1;
  logic          SDout = 1'b0;
  logic          SCLK, LRCLK, SDin, valid, tx_ack;
  logic [DW-1:0] lft_out = '0, rht_out = '0;
  logic [DW-1:0] lft_in, rht_in;

  int unsigned   n_cmp = 0, n_bad = 0;
  int unsigned   tcnt = 0, t = 0, t0 = 0, bitn = 0, src_mode = 0;
  logic [DW-1:0] lq[$], rq[$];
  logic [2*DW-1:0] pq[$];
  logic [2*DW-1:0] e;
  logic [DW-1:0] ref_lin = '0, ref_rin = '0;
  logic [DW-1:0] cur_l = '0, cur_r = '0, word = '0, cap = '0;
  logic          lr_q = 1'b0, sc_q = 1'b0, left_full = 1'b0;

  codec_intf #(.DW(DW)) dut (
    .MCLK(MCLK), .RSTn(RSTn), .SCLK(SCLK), .LRCLK(LRCLK),
    .SDout(SDout), .SDin(SDin), .lft_out(lft_out), .rht_out(rht_out),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid), .tx_ack(tx_ack)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input logic left);
    if (src_mode == 0) return left ? DW'(16'h1234) : DW'(16'hABCD);
    return DW'($urandom);
  endfunction

  // Reference, codec model and monitor share one per-cycle process.
  initial forever begin
    @(posedge MCLK);
    if (RSTn) begin
      t0 = tcnt % 512;
`ifdef CODEC_LOOPBACK_EN
      if (t0 == LD_L) lq.push_back(ref_lin);
      if (t0 == LD_R) rq.push_back(ref_rin);
`else
      if (t0 == LD_L) lq.push_back(lft_out);
      if (t0 == LD_R) rq.push_back(rht_out);
`endif
      tcnt++;
    end
    #1;
    t = tcnt % 512;
    if (LRCLK !== lr_q) begin
      if (RSTn) begin
        chk("lrclk_edge_cycle", t, LRCLK ? 256 : 0);
        if (lr_q) begin
          if (lq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_left: got %h with no expected sample", cap);
          end else chk("tx_left", cap, lq.pop_front());
        end else begin
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_right: got %h with no expected sample", cap);
          end else chk("tx_right", cap, rq.pop_front());
        end
      end
      if (LRCLK === 1'b1) begin
        cur_l = src_word(1'b1);
        word = cur_l;
        left_full = RSTn;
      end else begin
        cur_r = src_word(1'b0);
        word = cur_r;
        if (left_full && RSTn) begin
          pq.push_back({cur_l, cur_r});
          ref_lin = cur_l;
          ref_rin = cur_r;
        end
        left_full = 1'b0;
      end
      bitn = 0;
      SDout = word[DW-1];
    end else if (sc_q && !SCLK) begin
      bitn++;
      SDout = (bitn < DW) ? word[DW-1-bitn] : 1'b0;
    end
    if (!sc_q && SCLK) begin
      cap = DW'({cap, SDin});
      if (RSTn) begin
        chk("sclk_rise_phase", tcnt % 4, 2);
        if ((tcnt % 256) < ACK_T) chk("sdin_idle", SDin, 0);
      end
    end
    lr_q = LRCLK;
    sc_q = SCLK;
    if (RSTn) begin
      if (valid || (t == VLD_T && pq.size() != 0)) begin
        chk("valid", valid, (t == VLD_T) && (pq.size() != 0));
        if (valid && pq.size() != 0) begin
          e = pq.pop_front();
          chk("lft_in", lft_in, e[2*DW-1:DW]);
          chk("rht_in", rht_in, e[DW-1:0]);
        end
      end
      if (tx_ack || t == ACK_T) chk("tx_ack", tx_ack, t == ACK_T);
    end
  end

  task automatic wait_t(input int unsigned target);
    int unsigned n = 0;
    do begin
      @(negedge MCLK);
      n++;
    end while ((tcnt % 512) != target && n < 2000);
    if ((tcnt % 512) != target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cnt: got %0d expected %0d", tcnt % 512, target);
    end
  endtask

  // Caller is positioned just after a falling MCLK edge.
  task automatic do_reset(input int unsigned hold);
    RSTn = 1'b0;
    #1;
    chk("rst_sclk", SCLK, 0);
    chk("rst_lrclk", LRCLK, 0);
    chk("rst_sdin", SDin, 0);
    chk("rst_valid", valid, 0);
    chk("rst_tx_ack", tx_ack, 0);
    chk("rst_lft_in", lft_in, 0);
    chk("rst_rht_in", rht_in, 0);
    repeat (hold) @(negedge MCLK);
    lq.delete(); rq.delete(); pq.delete();
    left_full = 1'b0;
    ref_lin = '0;
    ref_rin = '0;
    tcnt = 0;
    RSTn = 1'b1;
  endtask

  task automatic random_run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge MCLK);
      if ($urandom_range(0, 63) == 0) lft_out = DW'($urandom);
      if ($urandom_range(0, 63) == 0) rht_out = DW'($urandom);
    end
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    lft_out = 16'h8001;
    rht_out = 16'h7FFE;
    src_mode = 0;
    #2 RSTn = 1'b0;
    repeat (3) @(negedge MCLK);
    do_reset(4);
    repeat (4 * 512) @(negedge MCLK);

    wait_t(ACK_T + 1);
    lft_out = 16'h0F0F;
    wait_t(256 + 52 * 4);
    lft_out = 16'hF0F0;
    repeat (3 * 512) @(negedge MCLK);

    src_mode = 1;
    random_run(6 * 512);

    wait_t(256 + 30 * 4);
    do_reset(7);
    random_run(4 * 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Digital-side serial master for the CS4272 codec, running in left-justified slave mode.
- Generates SCLK and LRCLK from MCLK.
- Deserialises codec ADC data (SDout) into parallel left/right samples.
- Serialises parallel DAC samples onto SDin.
- Sits directly between the codec pins and the filter/equaliser datapath.

Parameters:
- DW, 16, sample width in bits; legal range 1..32. Receive uses the first DW SCLK slots of each half-frame; transmit uses the last DW slots.

Ports:
- MCLK  in  1  master clock; all flops on posedge
- RSTn  in  1  asynchronous active-low reset
- SCLK  out  1  serial bit clock = MCLK/4
- LRCLK  out  1  frame clock = MCLK/512; high = left channel, low = right channel
- SDout  in  1  serial ADC data from codec
- SDin  out  1  serial DAC data to codec
- lft_out  in  DW  left sample to transmit
- rht_out  in  DW  right sample to transmit
- lft_in  out  DW  last received left sample
- rht_in  out  DW  last received right sample
- valid  out  1  one-cycle pulse: new lft_in/rht_in pair available
- tx_ack  out  1  one-cycle pulse: rht_out has just been sampled; datapath may change both inputs

Behaviour:
- Reset: RSTn is asynchronous and active-low; the clock is MCLK. Reset forces cnt, SCLK, LRCLK, SDin, lft_in, rht_in, valid, tx_ack, primed and all shift registers to 0. Reset asserted mid-frame aborts the frame immediately; no partial sample is ever presented.
- cnt: 9-bit free-running counter, wraps 511->0.
  - SCLK = cnt[1]; LRCLK = cnt[8]. Both are driven from flops, glitch-free.
  - LRCLK therefore leaves reset low (right phase).
  - Slot index idx = cnt[7:2], giving 64 SCLK periods per half-frame.
- Receive:
  - On the MCLK edge ending a cycle with cnt[1:0]==2'b10 and idx<DW, shift SDout into rx_sh, MSB first.
  - At the edge ending cnt[7:0]==DW*4-2 (last slot, 0x3E for DW=16):
    - cnt[8]=1: copy rx_sh to a left staging register and set primed.
    - cnt[8]=0 and primed=1: update lft_in <= staging and rht_in <= rx_sh together; valid=1 for exactly the following cycle.
  - The first right half-frame after reset is discarded; no valid is produced for it.
  - lft_in/rht_in hold between updates.
- Transmit:
  - At the edge ending cnt[7:0]==(64-DW)*4-1 (0xBF for DW=16), load tx_sh with lft_out if cnt[8]=1, else rht_out.
  - tx_ack=1 for one cycle after the rht_out load.
  - SDin = tx_sh[DW-1] while idx >= 64-DW, else 0.
  - tx_sh shifts left at each edge ending cnt[1:0]==2'b11, i.e. a bit change coincides with an SCLK fall.
  - Result: the final DW SCLK rises before each LRCLK edge carry the sample MSB-first.
  - A change on lft_out/rht_out outside the load cycle does not affect the slot in progress.
- Latency: a left sample is presented on SDin at most 512 MCLK after being sampled. valid asserts 0x3F MCLK after the right half-frame start.
- Simultaneous events: an LRCLK edge always coincides with an SCLK fall (cnt[1:0]==00); no receive or transmit action is scheduled on that cycle.

Optional Feature:
- CODEC_LOOPBACK_EN
  - Defined: transmit loads take lft_in/rht_in instead of lft_out/rht_out; lft_out/rht_out are ignored; tx_ack still pulses. This gives ADC->DAC loopback for board bring-up.
  - Undefined: normal behaviour as above.

Test Plan:
- Reset hold then release: SCLK/LRCLK/SDin/valid/lft_in/rht_in all 0; SCLK period 4 MCLK and LRCLK period 512 MCLK measured; first LRCLK rise at cycle 256.
- Codec model sourcing left=0x1234, right=0xABCD: lft_in=0x1234 and rht_in=0xABCD with a single-cycle valid; no valid during the first right half after reset.
- lft_out=0x8001, rht_out=0x7FFE held constant: codec aout_lft=0x8001, aout_rht=0x7FFE after two frames; SDin=0 during idx 0..47.
- Change lft_out from 0x0F0F to 0xF0F0 mid-transmit (idx 52): that frame still sends 0x0F0F; next frame sends 0xF0F0; tx_ack pulses once per frame.
- Assert RSTn low at idx 30 of a left half: all outputs 0 asynchronously; after release, the first valid appears only after a full left+right pair.
- CODEC_LOOPBACK_EN defined, codec sourcing 0x5A5A/0xA5A5: codec aout_lft/aout_rht equal 0x5A5A/0xA5A5 within three frames regardless of lft_out/rht_out.
